// File: rtl/multi_in_multi_out_fifo_lib.sv
// Purpose: N-in/M-out FIFO; valid write lanes compacted in lane order, read lanes show the oldest OUT_NUM entries.
// Latency: pushed data visible on out_* the cycle after the push; out_* is combinational from registers.
// Backpressure: in_rdy = (free_cnt >= IN_NUM), from current occupancy only; define OVERWRITE_EN to drop oldest instead.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   flush              synchronous clear of all entries (rst > flush > push/pop)
//   in_vld / in_data   per-lane write request, lane i at [i*DATA_SIZE +: DATA_SIZE]
//   in_rdy             all IN_NUM lanes can be accepted this cycle
//   out_vld / out_data lane j holds the j-th oldest entry
//   pick_rdy           per-lane consume; only the contiguous run from lane 0 pops
//   fifo_full/empty    occupancy flags; free_cnt = ENT_NUM - cnt
//   ovf                (OVERWRITE_EN only) one-cycle pulse when oldest entries were dropped
module multi_in_multi_out_fifo_lib #(
    parameter int ENT_NUM   = 8,
    parameter int IN_NUM    = 2,
    parameter int OUT_NUM   = 2,
    parameter int DATA_SIZE = 32,
    parameter int PTR_WIDTH = $clog2(ENT_NUM),
    parameter int CNT_WIDTH = $clog2(ENT_NUM + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [IN_NUM-1:0]            in_vld,
    input  logic [IN_NUM*DATA_SIZE-1:0]  in_data,
    output logic                         in_rdy,
    output logic [OUT_NUM-1:0]           out_vld,
    output logic [OUT_NUM*DATA_SIZE-1:0] out_data,
    input  logic [OUT_NUM-1:0]           pick_rdy,
    output logic                         fifo_full,
    output logic                         fifo_empty,
    output logic [CNT_WIDTH-1:0]         free_cnt
`ifdef OVERWRITE_EN
    ,
    output logic                         ovf
`endif
);

    // One extra bit over the occupancy width holds any pointer+offset or count+push sum.
    localparam int SUM_W = CNT_WIDTH + 1;
    typedef logic [SUM_W-1:0] sum_t;

    logic [DATA_SIZE-1:0] mem [ENT_NUM];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] cnt;

    logic [PTR_WIDTH-1:0] wr_idx [IN_NUM];
    sum_t                 push_num;
    sum_t                 pop_num;
    sum_t                 drop;
    sum_t                 rd_adv;
    sum_t                 cnt_nxt;
    logic                 run;

    // Offsets never exceed ENT_NUM, so one conditional subtract is a full modulo.
    function automatic logic [PTR_WIDTH-1:0] wrap(input sum_t v);
        sum_t r;
        r = (v >= sum_t'(ENT_NUM)) ? v - sum_t'(ENT_NUM) : v;
        return PTR_WIDTH'(r);
    endfunction

    always_comb begin
        free_cnt   = CNT_WIDTH'(ENT_NUM) - cnt;
        fifo_full  = (cnt == CNT_WIDTH'(ENT_NUM));
        fifo_empty = (cnt == '0);
`ifdef OVERWRITE_EN
        in_rdy     = 1'b1;
`else
        in_rdy     = (sum_t'(free_cnt) >= sum_t'(IN_NUM));
`endif
    end

    // Lane compaction: each valid lane takes the slot after all valid lanes below it.
    always_comb begin
        push_num = '0;
        for (int i = 0; i < IN_NUM; i++) begin
            wr_idx[i] = wrap(sum_t'(wr_ptr) + push_num);
            if (in_vld[i]) begin
                push_num = push_num + sum_t'(1);
            end
        end
        if (!in_rdy) begin
            push_num = '0;
        end
    end

    // Read side: lane j shows the j-th oldest entry; pops stop at the first lane not taken.
    always_comb begin
        pop_num = '0;
        run     = 1'b1;
        for (int j = 0; j < OUT_NUM; j++) begin
            out_vld[j] = (sum_t'(cnt) > sum_t'(j));
            out_data[j*DATA_SIZE +: DATA_SIZE] = mem[wrap(sum_t'(rd_ptr) + sum_t'(j))];
            if (run && out_vld[j] && pick_rdy[j]) begin
                pop_num = pop_num + sum_t'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
`ifdef OVERWRITE_EN
        // Anything that does not fit in free space plus this cycle's pops evicts the oldest survivors.
        drop = (push_num > (sum_t'(free_cnt) + pop_num)) ?
               push_num - (sum_t'(free_cnt) + pop_num) : '0;
`else
        drop = '0;
`endif
        rd_adv  = pop_num + drop;
        cnt_nxt = sum_t'(cnt) + push_num - pop_num - drop;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wrap(sum_t'(wr_ptr) + push_num);
            rd_ptr <= wrap(sum_t'(rd_ptr) + rd_adv);
            cnt    <= CNT_WIDTH'(cnt_nxt);
        end
    end

`ifdef OVERWRITE_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ovf <= 1'b0;
        end else begin
            ovf <= (drop != '0);
        end
    end
`endif

    // Storage is not reset; out_data is only meaningful where out_vld is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_NUM; i++) begin
            if (!rst && !flush && in_rdy && in_vld[i]) begin
                mem[wr_idx[i]] <= in_data[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

endmodule

// File: tb/tb_multi_in_multi_out_fifo_lib.sv
module tb_multi_in_multi_out_fifo_lib;

`ifdef OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  in_vld;
    logic [63:0] in_data;
    logic        in_rdy;
    logic [1:0]  out_vld;
    logic [63:0] out_data;
    logic [1:0]  pick_rdy;
    logic        fifo_full;
    logic        fifo_empty;
    logic [3:0]  free_cnt;
`ifdef OVERWRITE_EN
    logic        ovf;
`endif

    multi_in_multi_out_fifo_lib #(
        .ENT_NUM(8), .IN_NUM(2), .OUT_NUM(2), .DATA_SIZE(32)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
        .out_vld(out_vld), .out_data(out_data), .pick_rdy(pick_rdy),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .free_cnt(free_cnt)
`ifdef OVERWRITE_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a queue of entries, oldest at index 0.
    logic [31:0] q[$];
    logic [31:0] popped[$];
    logic        exp_ovf;
    int          vectors;
    int          miscompares;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int s;
        s = q.size();
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("out_vld%0d", j), 64'(out_vld[j]), 64'(s > j));
            if (s > j)
                chk($sformatf("out_data%0d", j), 64'(out_data[j*32 +: 32]), 64'(q[j]));
        end
        chk("in_rdy", 64'(in_rdy), 64'(OVW || (8 - s >= 2)));
        chk("free_cnt", 64'(free_cnt), 64'(8 - s));
        chk("fifo_full", 64'(fifo_full), 64'(s == 8));
        chk("fifo_empty", 64'(fifo_empty), 64'(s == 0));
`ifdef OVERWRITE_EN
        chk("ovf", 64'(ovf), 64'(exp_ovf));
`endif
    endtask

    // Apply one cycle of stimulus, advance the model by the same rules, then compare everything.
    task automatic step(input logic [1:0] vld, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] pick, input logic fl, input logic rs);
        int  s;
        int  n;
        bit  rdy;
        rst      = rs;
        flush    = fl;
        in_vld   = vld;
        in_data  = {d1, d0};
        pick_rdy = pick;
        s   = q.size();
        rdy = OVW || (8 - s >= 2);
        n   = 0;
        while (n < 2 && n < s && pick[n]) n++;
        if (rs || fl) n = 0;
        #1;
        for (int k = 0; k < n; k++) popped.push_back(out_data[k*32 +: 32]);
        @(posedge clk);
        #1;
        exp_ovf = 1'b0;
        if (rs || fl) begin
            q.delete();
        end else begin
            repeat (n) void'(q.pop_front());
            if (rdy) begin
                if (vld[0]) q.push_back(d0);
                if (vld[1]) q.push_back(d1);
            end
            while (q.size() > 8) begin
                void'(q.pop_front());
                exp_ovf = 1'b1;
            end
        end
        rst = 1'b0; flush = 1'b0; in_vld = '0; pick_rdy = '0;
        check_outputs();
    endtask

    initial begin
        int nxt;
        int cyc;
        logic [1:0]  v;
        logic [1:0]  p;
        logic [31:0] d0;
        logic [31:0] d1;
        vectors = 0; miscompares = 0; exp_ovf = 1'b0;
        rst = 1'b1; flush = 1'b0; in_vld = '0; in_data = '0; pick_rdy = '0;

        // 1. reset then idle
        step(2'b00, 0, 0, 2'b00, 1'b0, 1'b1);
        step(2'b00, 0, 0, 2'b00, 1'b0, 1'b1);
        chk("rst_out_vld", 64'(out_vld), 64'(2'b00));
        chk("rst_free_cnt", 64'(free_cnt), 64'd8);
        chk("rst_in_rdy", 64'(in_rdy), 64'd1);
        step(2'b00, 0, 0, 2'b00, 1'b0, 1'b0);

        // 2. single push on lane 1, then dual push with single pop
        step(2'b10, 32'h0, 32'hA, 2'b00, 1'b0, 1'b0);
        chk("t2_out_vld", 64'(out_vld), 64'(2'b01));
        chk("t2_lane0", 64'(out_data[31:0]), 64'hA);
        chk("t2_free_cnt", 64'(free_cnt), 64'd7);
        step(2'b11, 32'hB, 32'hC, 2'b01, 1'b0, 1'b0);
        chk("t2_lane0_b", 64'(out_data[31:0]), 64'hB);
        chk("t2_lane1_c", 64'(out_data[63:32]), 64'hC);

        // 3. fill to 7, reject, recover
        step(2'b11, 32'h1, 32'h2, 2'b00, 1'b0, 1'b0);
        step(2'b11, 32'h3, 32'h4, 2'b00, 1'b0, 1'b0);
        step(2'b01, 32'h5, 32'h0, 2'b00, 1'b0, 1'b0);
        if (!OVW) chk("t3_in_rdy_low", 64'(in_rdy), 64'd0);
        step(2'b11, 32'h6, 32'h7, 2'b11, 1'b0, 1'b0);
        if (!OVW) begin
            chk("t3_free_cnt", 64'(free_cnt), 64'd3);
            chk("t3_in_rdy_back", 64'(in_rdy), 64'd1);
        end

        // 4. non-prefix pick pops nothing
        step(2'b00, 0, 0, 2'b00, 1'b1, 1'b0);
        step(2'b11, 32'h8, 32'h9, 2'b00, 1'b0, 1'b0);
        step(2'b00, 0, 0, 2'b10, 1'b0, 1'b0);
        chk("t4_free_cnt", 64'(free_cnt), 64'd6);
        chk("t4_lane0", 64'(out_data[31:0]), 64'h8);
        chk("t4_lane1", 64'(out_data[63:32]), 64'h9);

        // reset mid-stream loses everything
        step(2'b11, 32'h55, 32'h66, 2'b00, 1'b0, 1'b0);
        step(2'b11, 32'h77, 32'h88, 2'b01, 1'b0, 1'b1);
        chk("rst_mid_empty", 64'(fifo_empty), 64'd1);

        // 5. random stream 0..19 across pointer wraps
        popped.delete();
        nxt = 0;
        cyc = 0;
        while ((nxt < 20 || q.size() != 0) && cyc < 2000) begin
            v  = 2'($urandom_range(0, 3));
            p  = 2'($urandom_range(0, 3));
            d0 = $urandom;
            d1 = $urandom;
            if (nxt >= 20) v = 2'b00;
            if (nxt == 19 && v == 2'b11) v = 2'b01;
            if (OVW && q.size() > 6) v = 2'b00;
            if (OVW || (8 - q.size() >= 2)) begin
                if (v[0]) begin d0 = 32'(nxt); nxt++; end
                if (v[1]) begin d1 = 32'(nxt); nxt++; end
            end
            step(v, d0, d1, p, 1'b0, 1'b0);
            cyc++;
        end
        chk("t5_no_timeout", 64'(cyc < 2000), 64'd1);
        chk("t5_popped_count", 64'(popped.size()), 64'd20);
        for (int i = 0; i < popped.size() && i < 20; i++)
            chk($sformatf("t5_order%0d", i), 64'(popped[i]), 64'(i));

        step(2'b11, 32'hDEAD, 32'hBEEF, 2'b11, 1'b1, 1'b0);
        chk("t5_flush_empty", 64'(fifo_empty), 64'd1);
        chk("t5_flush_free", 64'(free_cnt), 64'd8);

`ifdef OVERWRITE_EN
        // 6. overwrite of the oldest entries
        for (int k = 0; k < 4; k++)
            step(2'b11, 32'(2*k), 32'(2*k+1), 2'b00, 1'b0, 1'b0);
        step(2'b11, 32'hF00D, 32'hCAFE, 2'b00, 1'b0, 1'b0);
        chk("t6_ovf_pulse", 64'(ovf), 64'd1);
        step(2'b00, 0, 0, 2'b00, 1'b0, 1'b0);
        chk("t6_ovf_clear", 64'(ovf), 64'd0);
        chk("t6_lane0", 64'(out_data[31:0]), 64'd2);
        chk("t6_lane1", 64'(out_data[63:32]), 64'd3);
        chk("t6_full", 64'(fifo_full), 64'd1);
        popped.delete();
        repeat (4) step(2'b00, 0, 0, 2'b11, 1'b0, 1'b0);
        chk("t6_drain_count", 64'(popped.size()), 64'd8);
        if (popped.size() == 8) begin
            chk("t6_newest_x", 64'(popped[6]), 64'hF00D);
            chk("t6_newest_y", 64'(popped[7]), 64'hCAFE);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
